// File: rtl/dl_sequencer_if.sv
// ROM-download bus between hps_io and dl_sequencer: incoming ioctl byte
// stream on one side, decoded region write port on the other.
interface dl_sequencer_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [3:0]  rom_we;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    input  rom_we, rom_addr, rom_data
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    output rom_we, rom_addr, rom_data
  );
endinterface

// File: rtl/dl_sequencer.sv
// Decodes the HPS ROM-download stream into four ROM regions, checks the
// download length and holds the game core in reset until a good image settles.
module dl_sequencer #(
  parameter logic [15:0] R1_BASE  = 16'h4000,
  parameter logic [15:0] R2_BASE  = 16'h8000,
  parameter logic [15:0] R3_BASE  = 16'hA000,
  parameter logic [16:0] TOTAL    = 17'h0C000,
  parameter int          HOLD_CYC = 256
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             user_reset,
  dl_sequencer_if.slave    bus,
  output logic             core_reset,
  output logic             dl_done,
  output logic             dl_error,
  output logic [7:0]       checksum
);

  localparam int            HW        = $clog2(HOLD_CYC + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, SETTLE, RUN} state_t;

  state_t        state, state_next;
  logic [16:0]   byte_count;
  logic          reject;
  logic [HW-1:0] hold_cnt;
  logic [3:0]    rom_we_q;
  logic [15:0]   rom_addr_q;
  logic [7:0]    rom_data_q;

  logic [15:0]   addr_lo;
  logic          in_range;
  logic          wr_load;
  logic          check_ok;
  logic          load_entry;
  logic [3:0]    region_we;
  logic [15:0]   region_addr;

  // Bytes above the 64 KiB window or past TOTAL are rejected outright.
  assign addr_lo    = bus.ioctl_addr[15:0];
  assign in_range   = (bus.ioctl_addr[24:16] == 9'd0) && ({1'b0, addr_lo} < TOTAL);
  assign wr_load    = (state == LOAD) && bus.ioctl_wr;
  assign check_ok   = (byte_count == TOTAL) && !reject;
  assign load_entry = (state_next == LOAD) && (state != LOAD);

  always_comb begin
    region_we   = 4'b0000;
    region_addr = 16'h0000;
    if (addr_lo < R1_BASE) begin
      region_we   = 4'b0001;
      region_addr = addr_lo;
    end else if (addr_lo < R2_BASE) begin
      region_we   = 4'b0010;
      region_addr = addr_lo - R1_BASE;
    end else if (addr_lo < R3_BASE) begin
      region_we   = 4'b0100;
      region_addr = addr_lo - R2_BASE;
    end else begin
      region_we   = 4'b1000;
      region_addr = addr_lo - R3_BASE;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.ioctl_download) state_next = LOAD;
      LOAD:    if (!bus.ioctl_download) state_next = CHECK;
      CHECK:   state_next = check_ok ? SETTLE : IDLE;
      SETTLE: begin
        if (bus.ioctl_download)       state_next = LOAD;
        else if (hold_cnt == HOLD_LAST) state_next = RUN;
      end
      RUN:     if (bus.ioctl_download) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  // A new download starting from RUN must re-assert core_reset on the same
  // edge that enters LOAD, so the download level is folded in here.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rom_we_q   <= 4'b0000;
      rom_addr_q <= 16'h0000;
      rom_data_q <= 8'h00;
      byte_count <= 17'd0;
      checksum   <= 8'h00;
      reject     <= 1'b0;
      dl_done    <= 1'b0;
      dl_error   <= 1'b0;
      hold_cnt   <= '0;
      core_reset <= 1'b1;
    end else begin
      rom_we_q <= 4'b0000;
      if (load_entry) begin
        byte_count <= 17'd0;
        checksum   <= 8'h00;
        reject     <= 1'b0;
      end else if (wr_load) begin
        if (in_range) begin
          if (byte_count != 17'h1FFFF) byte_count <= byte_count + 17'd1;
          checksum <= checksum + bus.ioctl_dout;
        end else begin
          reject <= 1'b1;
        end
      end
      if (wr_load && in_range) begin
        rom_we_q   <= region_we;
        rom_addr_q <= region_addr;
        rom_data_q <= bus.ioctl_dout;
      end
      if (state == CHECK) begin
        dl_error <= !check_ok;
        if (check_ok) dl_done <= 1'b1;
      end
      hold_cnt   <= (state == SETTLE) ? hold_cnt + HW'(1) : '0;
      core_reset <= ((state == RUN) && !bus.ioctl_download) ? user_reset : 1'b1;
    end
  end

  assign bus.rom_we   = rom_we_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.rom_data = rom_data_q;

endmodule

// File: tb/tb_dl_sequencer.sv
// Directed bench for dl_sequencer: a default-sized instance for the full image
// flow and a shrunken instance (TOTAL=0xC0, HOLD_CYC=8) for reject/settle cases.
module tb_dl_sequencer;

  logic clk_sys;
  logic reset_n;
  logic user_reset;
  logic core_reset_a, dl_done_a, dl_error_a;
  logic core_reset_b, dl_done_b, dl_error_b;
  logic [7:0] checksum_a, checksum_b;

  int checks = 0;
  int errors = 0;
  int strobes;
  int n;
  int low_seen;

  dl_sequencer_if bus_a ();
  dl_sequencer_if bus_b ();

  dl_sequencer u_dut_a (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .user_reset (user_reset),
    .bus        (bus_a),
    .core_reset (core_reset_a),
    .dl_done    (dl_done_a),
    .dl_error   (dl_error_a),
    .checksum   (checksum_a)
  );

  dl_sequencer #(
    .R1_BASE  (16'h0040),
    .R2_BASE  (16'h0080),
    .R3_BASE  (16'h00A0),
    .TOTAL    (17'h000C0),
    .HOLD_CYC (8)
  ) u_dut_b (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .user_reset (user_reset),
    .bus        (bus_b),
    .core_reset (core_reset_b),
    .dl_done    (dl_done_b),
    .dl_error   (dl_error_b),
    .checksum   (checksum_b)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs seen after this returns reflect the inputs of the previous call.
  task automatic apply_stimulus(input bit sel, input logic dl, input logic wr,
                                input logic [24:0] a, input logic [7:0] d);
    @(posedge clk_sys);
    #1;
    if (!sel) begin
      bus_a.ioctl_download = dl;
      bus_a.ioctl_wr       = wr;
      bus_a.ioctl_addr     = a;
      bus_a.ioctl_dout     = d;
    end else begin
      bus_b.ioctl_download = dl;
      bus_b.ioctl_wr       = wr;
      bus_b.ioctl_addr     = a;
      bus_b.ioctl_dout     = d;
    end
  endtask

  initial begin
    reset_n    = 1'b1;
    user_reset = 1'b0;
    bus_a.ioctl_download = 1'b0; bus_a.ioctl_wr = 1'b0;
    bus_a.ioctl_addr = '0;       bus_a.ioctl_dout = '0;
    bus_b.ioctl_download = 1'b0; bus_b.ioctl_wr = 1'b0;
    bus_b.ioctl_addr = '0;       bus_b.ioctl_dout = '0;

    #2 reset_n = 1'b0;
    #2;
    check_output("rst_core_reset", 32'(core_reset_a), 32'd1);
    check_output("rst_dl_done",    32'(dl_done_a),    32'd0);
    check_output("rst_dl_error",   32'(dl_error_a),   32'd0);
    check_output("rst_rom_we",     32'(bus_a.rom_we), 32'd0);
    check_output("rst_checksum",   32'(checksum_a),   32'd0);
    repeat (3) @(posedge clk_sys);
    #1 reset_n = 1'b1;
    repeat (20) @(posedge clk_sys);
    #1;
    check_output("pwr_core_reset", 32'(core_reset_a), 32'd1);
    check_output("pwr_dl_done",    32'(dl_done_a),    32'd0);
    check_output("pwr_rom_we",     32'(bus_a.rom_we), 32'd0);

    // Full image, data = addr[7:0]; the last byte rides the falling download edge.
    strobes = 0;
    apply_stimulus(0, 1, 0, '0, '0);
    for (int i = 0; i < 'hC000; i++) begin
      apply_stimulus(0, logic'(i != 'hBFFF), 1, 25'(i), 8'(i));
      if (bus_a.rom_we != 4'b0000) strobes++;
      if (i - 1 == 'h3FFF) begin
        check_output("we_3fff",   32'(bus_a.rom_we),   32'h1);
        check_output("addr_3fff", 32'(bus_a.rom_addr), 32'h3FFF);
        check_output("data_3fff", 32'(bus_a.rom_data), 32'hFF);
      end
      if (i - 1 == 'h4000) begin
        check_output("we_4000",   32'(bus_a.rom_we),   32'h2);
        check_output("addr_4000", 32'(bus_a.rom_addr), 32'h0);
      end
      if (i - 1 == 'h9FFF) begin
        check_output("we_9fff",   32'(bus_a.rom_we),   32'h4);
        check_output("addr_9fff", 32'(bus_a.rom_addr), 32'h1FFF);
      end
      if (i - 1 == 'hA000) begin
        check_output("we_a000",   32'(bus_a.rom_we),   32'h8);
        check_output("addr_a000", 32'(bus_a.rom_addr), 32'h0);
      end
    end
    apply_stimulus(0, 0, 0, '0, '0);
    if (bus_a.rom_we != 4'b0000) strobes++;
    check_output("we_bfff",   32'(bus_a.rom_we),   32'h8);
    check_output("addr_bfff", 32'(bus_a.rom_addr), 32'h1FFF);
    check_output("strobe_count", 32'(strobes), 32'hC000);
    n = 0;
    while (core_reset_a === 1'b1 && n < 400) begin
      @(posedge clk_sys);
      #1;
      n++;
      if (n == 1) begin
        check_output("full_dl_error", 32'(dl_error_a), 32'd0);
        check_output("full_dl_done",  32'(dl_done_a),  32'd1);
      end
    end
    check_output("core_reset_fall_cycles", 32'(n), 32'd258);
    check_output("full_checksum", 32'(checksum_a), 32'h00);

    // user_reset in RUN is followed with one cycle of lag.
    @(posedge clk_sys);
    #1 user_reset = 1'b1;
    @(negedge clk_sys);
    check_output("user_reset_lag", 32'(core_reset_a), 32'd0);
    @(posedge clk_sys);
    #1;
    check_output("user_reset_hi", 32'(core_reset_a), 32'd1);
    user_reset = 1'b0;
    @(posedge clk_sys);
    #1;
    check_output("user_reset_lo", 32'(core_reset_a), 32'd0);

    // Short re-download from RUN.
    apply_stimulus(0, 1, 0, '0, '0);
    for (int i = 0; i < 'h100; i++) begin
      apply_stimulus(0, 1, 1, 25'(i), 8'(i));
      if (i == 0) begin
        check_output("redl_core_reset", 32'(core_reset_a), 32'd1);
        check_output("redl_checksum",   32'(checksum_a),   32'd0);
        check_output("redl_dl_done",    32'(dl_done_a),    32'd1);
      end
    end
    apply_stimulus(0, 0, 0, '0, '0);
    repeat (3) @(posedge clk_sys);
    #1;
    check_output("short_dl_error",   32'(dl_error_a),   32'd1);
    check_output("short_dl_done",    32'(dl_done_a),    32'd1);
    check_output("short_checksum",   32'(checksum_a),   32'h80);
    repeat (300) @(posedge clk_sys);
    #1;
    check_output("short_core_reset", 32'(core_reset_a), 32'd1);

    // Reset pulse in the middle of a download at byte 0x1234.
    apply_stimulus(0, 1, 0, '0, '0);
    for (int i = 0; i < 'h1234; i++) apply_stimulus(0, 1, 1, 25'(i), 8'(i));
    apply_stimulus(0, 1, 1, 25'h1234, 8'h34);
    check_output("mid_we_1233", 32'(bus_a.rom_we), 32'h1);
    #1 reset_n = 1'b0;
    #1;
    check_output("mid_rst_rom_we",     32'(bus_a.rom_we),   32'd0);
    check_output("mid_rst_rom_addr",   32'(bus_a.rom_addr), 32'd0);
    check_output("mid_rst_rom_data",   32'(bus_a.rom_data), 32'd0);
    check_output("mid_rst_core_reset", 32'(core_reset_a),   32'd1);
    check_output("mid_rst_dl_done",    32'(dl_done_a),      32'd0);
    check_output("mid_rst_dl_error",   32'(dl_error_a),     32'd0);
    check_output("mid_rst_checksum",   32'(checksum_a),     32'd0);
    @(posedge clk_sys);
    #1;
    bus_a.ioctl_wr = 1'b0;
    reset_n = 1'b1;
    apply_stimulus(0, 1, 1, 25'h4005, 8'h5A);
    apply_stimulus(0, 1, 0, '0, '0);
    check_output("post_rst_we",       32'(bus_a.rom_we),   32'h2);
    check_output("post_rst_addr",     32'(bus_a.rom_addr), 32'h5);
    check_output("post_rst_data",     32'(bus_a.rom_data), 32'h5A);
    check_output("post_rst_checksum", 32'(checksum_a),     32'h5A);
    apply_stimulus(0, 0, 0, '0, '0);

    // Small instance: writes outside LOAD are ignored.
    apply_stimulus(1, 0, 1, 25'h10, 8'h77);
    apply_stimulus(1, 0, 0, '0, '0);
    check_output("idle_wr_ignored", 32'(bus_b.rom_we), 32'd0);

    // Small instance: good image, then re-download from inside SETTLE.
    apply_stimulus(1, 1, 0, '0, '0);
    for (int i = 0; i < 'hC0; i++) apply_stimulus(1, logic'(i != 'hBF), 1, 25'(i), 8'(i));
    apply_stimulus(1, 0, 0, '0, '0);
    check_output("b_we_bf",   32'(bus_b.rom_we),   32'h8);
    check_output("b_addr_bf", 32'(bus_b.rom_addr), 32'h1F);
    @(posedge clk_sys);
    #1;
    check_output("b_good_dl_error", 32'(dl_error_b), 32'd0);
    check_output("b_good_dl_done",  32'(dl_done_b),  32'd1);
    check_output("b_good_checksum", 32'(checksum_b), 32'hA0);
    repeat (2) @(posedge clk_sys);
    apply_stimulus(1, 1, 0, '0, '0);
    low_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_sys);
      #1;
      if (core_reset_b !== 1'b1) low_seen++;
    end
    check_output("settle_redl_core_reset_lows", 32'(low_seen), 32'd0);
    check_output("settle_redl_checksum",        32'(checksum_b), 32'd0);

    // Full-length image plus two out-of-range bytes must be flagged bad.
    apply_stimulus(1, 1, 1, 25'h000C0, 8'h55);
    apply_stimulus(1, 1, 1, 25'h10005, 8'h55);
    check_output("reject_total_no_strobe", 32'(bus_b.rom_we), 32'd0);
    apply_stimulus(1, 1, 0, '0, '0);
    check_output("reject_high_no_strobe", 32'(bus_b.rom_we), 32'd0);
    for (int i = 0; i < 'hC0; i++) apply_stimulus(1, logic'(i != 'hBF), 1, 25'(i), 8'(i));
    apply_stimulus(1, 0, 0, '0, '0);
    @(posedge clk_sys);
    #1;
    check_output("reject_dl_error", 32'(dl_error_b), 32'd1);
    check_output("reject_dl_done",  32'(dl_done_b),  32'd1);
    check_output("reject_checksum", 32'(checksum_b), 32'hA0);
    repeat (20) @(posedge clk_sys);
    #1;
    check_output("reject_core_reset", 32'(core_reset_b), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
